// File: rtl/clock_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// The optional SYNC_ALIGN_EN macro adds a global phase-realignment input.
package clock_div_pkg;

  localparam int WIDTH_DEF       = 28;
  localparam int DEFAULT_DIV_DEF = 200000;

  // Channel-index width; never zero so a single-channel build still has a legal select.
  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Divisor-load handshake between a configuration master and the divider bank.
// No build options apply to this file (SYNC_ALIGN_EN only affects the top and channels).
interface clock_divider_multi_if
  import clock_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = WIDTH_DEF
);

  localparam int CW = chan_width(CHANNELS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_chan;
  logic [WIDTH-1:0] cfg_div;

  modport master (output cfg_valid, cfg_chan, cfg_div, input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_chan, cfg_div, output cfg_ready);

endinterface

// File: rtl/clock_div_channel.sv
// One divider channel: active/shadow divisor, pending flag, counter, registered outputs.
// With SYNC_ALIGN_EN defined, sync_req restarts the channel and applies any pending divisor.
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             en,
`ifdef SYNC_ALIGN_EN
  input  logic             sync_req,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  output logic             clock_out,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH:0]   half;
  logic             stopped;
  logic             wrap;
  logic             high_phase;
  logic             apply;

  always_comb begin
    stopped    = (div_q == '0);
    wrap       = en && !stopped && (cnt_q == div_q - WIDTH'(1));
    // Extra bit keeps (D+1)/2 exact when D is all ones.
    half       = ({1'b0, div_q} + (WIDTH+1)'(1)) >> 1;
    high_phase = !stopped && ({1'b0, cnt_q} < half);
    // Registered pending only: a load accepted on a wrap edge waits for the next wrap.
    apply      = pending && (wrap || stopped);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      div_q     <= WIDTH'(DEFAULT_DIV);
      shadow_q  <= WIDTH'(DEFAULT_DIV);
      pending   <= 1'b0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end
`ifdef SYNC_ALIGN_EN
    else if (sync_req) begin
      cnt_q     <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      if (pending) begin
        div_q   <= shadow_q;
        pending <= 1'b0;
      end else if (load) begin
        shadow_q <= load_div;
        pending  <= 1'b1;
      end
    end
`endif
    else begin
      tick <= wrap;
      if (en) clock_out <= high_phase;

      if (apply) begin
        div_q   <= shadow_q;
        cnt_q   <= '0;
        pending <= 1'b0;
      end else if (wrap) begin
        cnt_q <= '0;
      end else if (en && !stopped) begin
        cnt_q <= cnt_q + WIDTH'(1);
      end

      // A load is only accepted while nothing is pending, so it never collides with apply.
      if (load) begin
        shadow_q <= load_div;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Bank of independent programmable clock dividers with a shared divisor-load port.
// Define SYNC_ALIGN_EN to add sync_req, which realigns every channel to count 0.
module clock_divider_multi
  import clock_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 en,
`ifdef SYNC_ALIGN_EN
  input  logic                 sync_req,
`endif
  clock_divider_multi_if.slave cfg,
  output logic [CHANNELS-1:0]  clock_out,
  output logic [CHANNELS-1:0]  tick
);

  localparam int CW = chan_width(CHANNELS);

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] load;
  logic                ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ready = 1'b1;
    load  = '0;
    // Out-of-range channels match nothing: ready stays high and the load is dropped.
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == CW'(i)) ready = !pending[i];
    end
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = cfg.cfg_valid && ready && (cfg.cfg_chan == CW'(i));
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clock_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .en        (en),
`ifdef SYNC_ALIGN_EN
      .sync_req  (sync_req),
`endif
      .load      (load[g]),
      .load_div  (cfg.cfg_div),
      .clock_out (clock_out[g]),
      .tick      (tick[g]),
      .pending   (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (CHANNELS=2, WIDTH=8, DEFAULT_DIV=4).
// The sync_req steps are compiled in only when SYNC_ALIGN_EN is defined.
module tb_clock_divider_multi;
  import clock_div_pkg::*;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int DD = 4;

  logic          clock_in = 1'b0;
  logic          reset_n;
  logic          en;
`ifdef SYNC_ALIGN_EN
  logic          sync_req;
`endif
  logic [CH-1:0] clock_out;
  logic [CH-1:0] tick;

  int total = 0;
  int bad   = 0;

  // Channel 0 expectations for edges 11..17 around the D=4 -> D=5 switch.
  int exp_co0[7] = '{0, 0, 1, 1, 1, 0, 0};
  int exp_t0 [7] = '{0, 1, 0, 0, 0, 0, 1};

  clock_divider_multi_if #(.CHANNELS(CH), .WIDTH(W)) cfg ();

  clock_divider_multi #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DD)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .en        (en),
`ifdef SYNC_ALIGN_EN
    .sync_req  (sync_req),
`endif
    .cfg       (cfg.slave),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always #5 clock_in = ~clock_in;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic load_req(input int ch, input int div);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan  = 1'(ch);
    cfg.cfg_div   = W'(div);
    step(1);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic ready_of(input int ch, output logic r);
    cfg.cfg_chan = 1'(ch);
    #1;
    r = cfg.cfg_ready;
  endtask

  // Free-running reference for a channel restarted at count 0; k = edges since restart (1-based).
  function automatic logic ref_co(input int k, input int d);
    return ((k - 1) % d) < ((d + 1) / 2);
  endfunction

  function automatic logic ref_tick(input int k, input int d);
    return ((k - 1) % d) == (d - 1);
  endfunction

  initial begin
    logic r;
    reset_n       = 1'b0;
    en            = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_chan  = '0;
    cfg.cfg_div   = '0;
`ifdef SYNC_ALIGN_EN
    sync_req      = 1'b0;
`endif

    step(2);
    check("reset_clock_out", 32'(clock_out), 32'h0);
    check("reset_tick",      32'(tick),      32'h0);
    check("reset_ready0",    32'(cfg.cfg_ready), 32'h1);

    // Edges 1..8: default divisor 4 on both channels.
    reset_n = 1'b1;
    en      = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("d4_clock_out", 32'(clock_out), 32'({ref_co(k, DD), ref_co(k, DD)}));
      check("d4_tick",      32'(tick),      32'({ref_tick(k, DD), ref_tick(k, DD)}));
    end

    // Edge 9, then ch0 load D=5 accepted on edge 10 (ch0 cnt=1).
    step(1);
    load_req(0, 5);
    ready_of(0, r);
    check("d5_ready0_pending", 32'(r), 32'h0);
    ready_of(1, r);
    check("d5_ready1_free", 32'(r), 32'h1);
    ready_of(0, r);
    for (int k = 11; k <= 17; k++) begin
      step(1);
      check("d5_clock_out0", 32'(clock_out[0]), 32'(exp_co0[k-11]));
      check("d5_tick0",      32'(tick[0]),      32'(exp_t0[k-11]));
      check("d5_clock_out1", 32'(clock_out[1]), 32'((k % 4 == 1) || (k % 4 == 2)));
      check("d5_tick1",      32'(tick[1]),      32'(k % 4 == 0));
      if (k == 11) check("d5_ready0_wait",    32'(cfg.cfg_ready), 32'h0);
      if (k == 12) check("d5_ready0_applied", 32'(cfg.cfg_ready), 32'h1);
    end

    // ch1: D=1 accepted at edge 18, applied at its wrap on edge 20.
    load_req(1, 1);
    ready_of(1, r);
    check("d1_ready1_pending", 32'(r), 32'h0);
    step(2);
    check("d1_wrap_tick1", 32'(tick[1]), 32'h1);
    check("d1_wrap_co1",   32'(clock_out[1]), 32'h0);
    check("d1_ready1",     32'(cfg.cfg_ready), 32'h1);
    for (int k = 21; k <= 23; k++) begin
      step(1);
      check("d1_co1",   32'(clock_out[1]), 32'h1);
      check("d1_tick1", 32'(tick[1]), 32'h1);
    end
    // D=0 accepted at edge 24, applied at edge 25, outputs zero from edge 26.
    load_req(1, 0);
    check("d0_accept_co1", 32'(clock_out[1]), 32'h1);
    check("d0_ready1",     32'(cfg.cfg_ready), 32'h0);
    step(1);
    check("d0_apply_co1",  32'(clock_out[1]), 32'h1);
    check("d0_ready1_clr", 32'(cfg.cfg_ready), 32'h1);
    step(1);
    check("d0_stopped_co1",   32'(clock_out[1]), 32'h0);
    check("d0_stopped_tick1", 32'(tick[1]), 32'h0);

    // ch0 (D=5, cnt=4) load D=4 on its wrap edge 27: must wait for the wrap at edge 32.
    load_req(0, 4);
    check("coinc_tick0",  32'(tick[0]), 32'h1);
    check("coinc_ready0", 32'(cfg.cfg_ready), 32'h0);
    step(4);
    check("coinc_wait_ready0", 32'(cfg.cfg_ready), 32'h0);
    check("coinc_wait_co0",    32'(clock_out[0]), 32'h0);
    step(1);
    check("coinc_apply_tick0",  32'(tick[0]), 32'h1);
    check("coinc_apply_ready0", 32'(cfg.cfg_ready), 32'h1);
    check("stopped_ch1_co",     32'(clock_out[1]), 32'h0);

    // ch0 now D=4; load D=2 accepted in the cnt==3 cycle (edge 36), applied at edge 40.
    step(3);
    check("c3_co0_before", 32'(clock_out[0]), 32'h0);
    load_req(0, 2);
    check("c3_tick0",  32'(tick[0]), 32'h1);
    check("c3_ready0", 32'(cfg.cfg_ready), 32'h0);
    step(1);
    check("c3_e37_co0", 32'(clock_out[0]), 32'h1);
    step(1);
    check("c3_e38_co0",   32'(clock_out[0]), 32'h1);
    check("c3_e38_tick0", 32'(tick[0]), 32'h0);
    step(2);
    check("c3_e40_tick0",  32'(tick[0]), 32'h1);
    check("c3_e40_co0",    32'(clock_out[0]), 32'h0);
    check("c3_e40_ready0", 32'(cfg.cfg_ready), 32'h1);
    step(1);
    check("d2_e41_co0",   32'(clock_out[0]), 32'h1);
    step(1);
    check("d2_e42_tick0", 32'(tick[0]), 32'h1);
    step(1);
    check("d2_e43_co0",   32'(clock_out[0]), 32'h1);

    // Freeze for 10 edges with ch0 at cnt=1, then resume from that count.
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("freeze_co0",   32'(clock_out[0]), 32'h1);
      check("freeze_tick0", 32'(tick[0]), 32'h0);
    end
    en = 1'b1;
    step(1);
    check("resume_co0",   32'(clock_out[0]), 32'h0);
    check("resume_tick0", 32'(tick[0]), 32'h1);
    step(1);
    check("resume2_co0",  32'(clock_out[0]), 32'h1);

    // Reset mid-period with a simultaneous load that must be lost.
    reset_n = 1'b0;
    load_req(0, 7);
    check("rst_clock_out", 32'(clock_out), 32'h0);
    check("rst_tick",      32'(tick), 32'h0);
    check("rst_ready0",    32'(cfg.cfg_ready), 32'h1);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("post_rst_clock_out", 32'(clock_out), 32'({ref_co(k, DD), ref_co(k, DD)}));
      check("post_rst_tick",      32'(tick),      32'({ref_tick(k, DD), ref_tick(k, DD)}));
    end
    check("post_rst_ready0", 32'(cfg.cfg_ready), 32'h1);

`ifdef SYNC_ALIGN_EN
    // ch1 to D=6 (applied at edge 64), run out of phase, then realign both.
    load_req(1, 6);
    step(7);
    ready_of(1, r);
    check("sync_ready1", 32'(r), 32'h1);
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    check("sync_clock_out", 32'(clock_out), 32'h0);
    check("sync_tick",      32'(tick), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("sync_run_clock_out", 32'(clock_out), 32'({ref_co(k, 6), ref_co(k, DD)}));
      check("sync_run_tick",      32'(tick),      32'({ref_tick(k, 6), ref_tick(k, DD)}));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
